player_state_engine: RTL

- Per-player game-state producer that feeds the frame renderer. It generates the direction, x, y and state values that the renderer draws.
- Advances player position once per video frame from button inputs and blocks movement into counter tiles.
- Performs pick-up, drop and chop interactions on the shared object grid through a request/grant write port.
- One instance per player. A shared grid store arbitrates the write requests.

---
 rtl/player_state_engine_if.sv | 11 +
 rtl/player_state_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/player_state_engine_if.sv
// rtl/player_state_engine_if.sv - grid write request/grant port between a player engine and the shared grid store
interface player_state_engine_if;
  logic       req;
  logic       gnt;
  logic [2:0] wx;
  logic [3:0] wy;
  logic [3:0] wdata;

  modport master (output req, wx, wy, wdata, input gnt);
  modport slave  (input req, wx, wy, wdata, output gnt);
endinterface

// File: rtl/player_state_engine.sv
// rtl/player_state_engine.sv - per-player movement and pick-up/drop/chop engine, stepped once per video frame
module player_state_engine #(
  parameter int TILE_PX     = 32,
  parameter int GRID_W      = 8,
  parameter int GRID_H      = 13,
  parameter int SPEED       = 2,
  parameter int BODY_PX     = 16,
  parameter int CHOP_FRAMES = 90,
  parameter int START_X     = 48,
  parameter int START_Y     = 48
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       vsync,
  input  logic                       game_active,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_action,
  input  logic                       btn_chop,
  input  logic [GRID_W*GRID_H-1:0]   counter_mask,
  input  logic [GRID_W*GRID_H*4-1:0] object_grid,
  output logic [8:0]                 player_x,
  output logic [8:0]                 player_y,
  output logic [1:0]                 player_direction,
  output logic [3:0]                 player_state,
  player_state_engine_if.master      grid
);

  localparam int SHIFT = $clog2(TILE_PX);
  localparam int IW    = $clog2(GRID_W * GRID_H);
  localparam int MAX_X = GRID_W * TILE_PX - BODY_PX;
  localparam int MAX_Y = GRID_H * TILE_PX - BODY_PX;
  localparam int REACH = TILE_PX - BODY_PX / 4;
  localparam int CW    = $clog2(CHOP_FRAMES + 1);
  localparam logic [3:0] NONE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_ACT, S_REQ} fsm_t;

  fsm_t          fsm;
  logic          vs_q, tick, act_q, action_pend, moved;
  logic [3:0]    pend_state;
  logic [CW-1:0] chop_cnt;

  function automatic logic [IW-1:0] tile_index(input int x, input int y);
    return IW'((y >>> SHIFT) * GRID_W + (x >>> SHIFT));
  endfunction

  function automatic logic in_grid(input int x, input int y);
    return (x >= 0) && (y >= 0) && (x < GRID_W * TILE_PX) && (y < GRID_H * TILE_PX);
  endfunction

  function automatic logic counter_at(input int x, input int y);
    return in_grid(x, y) ? counter_mask[tile_index(x, y)] : 1'b0;
  endfunction

  // Grid object -> held item; NONE marks objects that cannot be picked up.
  function automatic logic [3:0] pick_code(input logic [3:0] g);
    case (g)
      4'd1:    return 4'd2;
      4'd2:    return 4'd3;
      4'd3:    return 4'd6;
      4'd4:    return 4'd7;
      4'd5:    return 4'd4;
      4'd7:    return 4'd5;
      4'd10:   return 4'd8;
      default: return NONE;
    endcase
  endfunction

  function automatic logic [3:0] drop_code(input logic [3:0] p);
    case (p)
      4'd2:    return 4'd1;
      4'd3:    return 4'd2;
      4'd6:    return 4'd3;
      4'd7:    return 4'd4;
      4'd4:    return 4'd5;
      4'd5:    return 4'd7;
      4'd8:    return 4'd10;
      default: return NONE;
    endcase
  endfunction

  int            cand_x, cand_y, face_px, face_py;
  logic [1:0]    dir_n;
  logic          any_btn, blocked, face_ok, pick_ok, drop_ok, chop_ok;
  logic [3:0]    face_obj;
  logic [IW-1:0] face_idx;

  always_comb begin
    cand_x  = int'(player_x);
    cand_y  = int'(player_y);
    dir_n   = player_direction;
    any_btn = 1'b1;
    if (btn_up) begin
      dir_n  = 2'd2;
      cand_y = cand_y - SPEED;
    end else if (btn_down) begin
      dir_n  = 2'd3;
      cand_y = cand_y + SPEED;
    end else if (btn_left) begin
      dir_n  = 2'd0;
      cand_x = cand_x - SPEED;
    end else if (btn_right) begin
      dir_n  = 2'd1;
      cand_x = cand_x + SPEED;
    end else begin
      any_btn = 1'b0;
    end
    if (cand_x < 0) cand_x = 0; else if (cand_x > MAX_X) cand_x = MAX_X;
    if (cand_y < 0) cand_y = 0; else if (cand_y > MAX_Y) cand_y = MAX_Y;
    // Far corners sit on x+BODY_PX / y+BODY_PX, so touching a counter edge also blocks.
    blocked = counter_at(cand_x, cand_y) | counter_at(cand_x + BODY_PX, cand_y) |
              counter_at(cand_x, cand_y + BODY_PX) | counter_at(cand_x + BODY_PX, cand_y + BODY_PX);

    face_px = int'(player_x) + BODY_PX / 2;
    face_py = int'(player_y) + BODY_PX / 2;
    case (player_direction)
      2'd0:    face_px = face_px - REACH;
      2'd1:    face_px = face_px + REACH;
      2'd2:    face_py = face_py - REACH;
      default: face_py = face_py + REACH;
    endcase
    face_idx = tile_index(face_px, face_py);
    face_ok  = counter_at(face_px, face_py);
    face_obj = face_ok ? object_grid[{face_idx, 2'b00} +: 4] : 4'd0;

    pick_ok = face_ok && (player_state == 4'd0) && (pick_code(face_obj) != NONE);
    drop_ok = face_ok && (face_obj == 4'd0) && (drop_code(player_state) != NONE);
    chop_ok = btn_chop && !moved && face_ok && (face_obj == 4'd1) &&
              (player_state == 4'd0 || player_state == 4'd1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm              <= S_IDLE;
      vs_q             <= 1'b1;
      tick             <= 1'b0;
      act_q            <= 1'b0;
      action_pend      <= 1'b0;
      moved            <= 1'b0;
      pend_state       <= 4'd0;
      chop_cnt         <= '0;
      player_x         <= 9'(START_X);
      player_y         <= 9'(START_Y);
      player_direction <= 2'd3;
      player_state     <= 4'd0;
      grid.req         <= 1'b0;
      grid.wx          <= 3'd0;
      grid.wy          <= 4'd0;
      grid.wdata       <= 4'd0;
    end else begin
      vs_q  <= vsync;
      tick  <= vs_q & ~vsync;
      act_q <= btn_action;
      if (!game_active) begin
        grid.req <= 1'b0;
        fsm      <= S_IDLE;
      end else begin
        case (fsm)
          S_IDLE: if (tick) fsm <= S_MOVE;
          S_MOVE: begin
            if (any_btn) player_direction <= dir_n;
            if (any_btn && !blocked) begin
              player_x <= 9'(cand_x);
              player_y <= 9'(cand_y);
            end
            moved <= any_btn && !blocked &&
                     (cand_x != int'(player_x) || cand_y != int'(player_y));
            fsm   <= S_ACT;
          end
          S_ACT: begin
            action_pend <= 1'b0;
            grid.wx     <= 3'(face_px >>> SHIFT);
            grid.wy     <= 4'(face_py >>> SHIFT);
            fsm         <= S_IDLE;
            if (action_pend && (pick_ok || drop_ok)) begin
              // Held item only changes when the grant arrives.
              pend_state <= pick_ok ? pick_code(face_obj) : 4'd0;
              grid.wdata <= pick_ok ? 4'd0 : drop_code(player_state);
              grid.req   <= 1'b1;
              fsm        <= S_REQ;
            end else if (chop_ok) begin
              if (chop_cnt == CW'(CHOP_FRAMES - 1)) begin
                chop_cnt     <= '0;
                player_state <= 4'd0;
                pend_state   <= 4'd0;
                grid.wdata   <= 4'd2;
                grid.req     <= 1'b1;
                fsm          <= S_REQ;
              end else begin
                chop_cnt     <= chop_cnt + CW'(1);
                player_state <= 4'd1;
              end
            end else begin
              chop_cnt <= '0;
              if (player_state == 4'd1) player_state <= 4'd0;
              else if (player_state == 4'd8 && btn_chop) player_state <= 4'd9;
              else if (player_state == 4'd9 && !btn_chop) player_state <= 4'd8;
            end
          end
          S_REQ: if (grid.gnt) begin
            grid.req     <= 1'b0;
            player_state <= pend_state;
            fsm          <= S_IDLE;
          end
          default: fsm <= S_IDLE;
        endcase
      end
      if (btn_action && !act_q) action_pend <= 1'b1;
    end
  end

endmodule
